// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants and types for the PS/2 keyboard controller: prefix bytes,
// register map, status bit positions, handshake states and the event format.
package ps2_kbd_ctrl_pkg;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;
    localparam logic [7:0] PS2_ERR0       = 8'h00;
    localparam logic [7:0] PS2_ERR1       = 8'hFF;

    localparam logic PS2_ADDR_DATA = 1'b0;
    localparam logic PS2_ADDR_STAT = 1'b1;

    localparam int ST_NEMPTY = 7;
    localparam int ST_EXT    = 6;
    localparam int ST_BRK    = 5;
    localparam int ST_OVR    = 4;
    localparam int ST_ERR    = 3;
    localparam int ST_IRQEN  = 2;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_IRQEN = 1;

    typedef enum logic {
        HS_WAIT = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with flush; a push into a full FIFO is still taken
// when a pop happens in the same clock, otherwise it is dropped and flagged.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             n_res,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign drop    = push & ~flush & full & ~do_pop;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: receiver handshake, prefix folding into tagged
// events, event FIFO, and a DATA/STATUS-CTRL register window with interrupt.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TO_TICKS   = 1023
) (
    input  logic       clk,
    input  logic       n_res,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       rx_ack,
    input  logic       tim_tick,
    input  logic       cs,
    input  logic       addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);
    localparam logic [9:0] TO_LAST = 10'(TO_TICKS - 1);

    hs_state_e  hs_state_q, hs_state_d;
    logic       capture;
    logic [7:0] byte_q;
    logic       byte_vld_q;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic [9:0] to_cnt_q, to_cnt_d;
    logic       err_q, ovr_q, irq_en_q, irq_q;
    logic       push, err_set, pfx_pending;
    evt_t       push_evt, head;
    logic       fifo_empty, fifo_drop, unused_full, unused_din;
    logic       rd_data, rd_stat, wr_ctrl, flush;

    assign rd_data     = cs & rd & (addr == PS2_ADDR_DATA);
    assign rd_stat     = cs & rd & (addr == PS2_ADDR_STAT);
    assign wr_ctrl     = cs & wr & (addr == PS2_ADDR_STAT);
    assign flush       = wr_ctrl & din[CTRL_FLUSH];
    assign unused_din  = ^din[7:2];
    assign pfx_pending = ext_q | brk_q | (skip_q != 3'd0);
    assign rx_ack      = (hs_state_q == HS_ACK);
    assign irq         = irq_q;

    // ACK persists until the receiver drops done, so each assertion yields one byte.
    always_comb begin
        hs_state_d = hs_state_q;
        capture    = 1'b0;
        case (hs_state_q)
            HS_WAIT: if (rx_done) begin
                capture    = 1'b1;
                hs_state_d = HS_ACK;
            end
            HS_ACK:  if (!rx_done) hs_state_d = HS_WAIT;
            default: hs_state_d = HS_WAIT;
        endcase
    end

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        to_cnt_d = to_cnt_q;
        push     = 1'b0;
        push_evt = {ext_q, brk_q, byte_q};
        err_set  = 1'b0;
        if (byte_vld_q) begin
            to_cnt_d = '0;
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (byte_q == PS2_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_PFX_BRK) begin
                brk_d = 1'b1;
            end else if (byte_q == PS2_PFX_PAUSE) begin
                push     = 1'b1;
                push_evt = {1'b1, 1'b0, byte_q};
                ext_d    = 1'b0;
                brk_d    = 1'b0;
                skip_d   = PS2_PAUSE_SKIP;
            end else if (byte_q == PS2_ERR0 || byte_q == PS2_ERR1) begin
                err_set = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end else if (pfx_pending) begin
            if (tim_tick) begin
                if (to_cnt_q == TO_LAST) begin
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                    skip_d   = '0;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 10'd1;
                end
            end
        end else begin
            to_cnt_d = '0;
        end
        if (flush) begin
            ext_d    = 1'b0;
            brk_d    = 1'b0;
            skip_d   = '0;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            hs_state_q <= HS_WAIT;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            hs_state_q <= hs_state_d;
            byte_vld_q <= capture;
            if (capture) byte_q <= rx_data;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            to_cnt_q   <= to_cnt_d;
            // A new error/overflow in the same clock as the STATUS read survives it.
            err_q      <= (err_q & ~rd_stat) | err_set;
            ovr_q      <= (ovr_q & ~rd_stat) | fifo_drop;
            if (wr_ctrl) irq_en_q <= din[CTRL_IRQEN];
            irq_q      <= irq_en_q & ~fifo_empty;
        end
    end

    ps2_evt_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_res     (n_res),
        .push      (push),
        .push_data (push_evt),
        .pop       (rd_data),
        .flush     (flush),
        .head      (head),
        .full      (unused_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    always_comb begin
        dout = '0;
        if (addr == PS2_ADDR_DATA) begin
            if (!fifo_empty) dout = head.code;
        end else begin
            dout[ST_NEMPTY] = ~fifo_empty;
            dout[ST_EXT]    = ~fifo_empty & head.ext;
            dout[ST_BRK]    = ~fifo_empty & head.brk;
            dout[ST_OVR]    = ovr_q;
            dout[ST_ERR]    = err_q;
            dout[ST_IRQEN]  = irq_en_q;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: queue-based event model compared every
// cycle, plus directed register reads with hand-computed values.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

    localparam int DEPTH    = 8;
    localparam int TO_TICKS = 1023;

    logic       clk = 1'b0;
    logic       n_res = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ack;
    logic       tim_tick = 1'b0;
    logic       cs = 1'b0;
    logic       addr = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    ps2_kbd_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TO_TICKS   (TO_TICKS)
    ) dut (
        .clk      (clk),
        .n_res    (n_res),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .rx_ack   (rx_ack),
        .tim_tick (tim_tick),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .din      (din),
        .dout     (dout),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] m_q[$];
    logic       m_ack, m_pend, m_ext, m_brk, m_err, m_ovr, m_irq_en, m_irq;
    logic [7:0] m_pb;
    int         m_skip, m_ticks;

    always @(posedge clk or negedge n_res) begin
        logic       had_byte, pend, popped, do_push;
        logic [7:0] b;
        logic [9:0] item;
        int         sz;
        if (!n_res) begin
            m_q.delete();
            m_ack = 0; m_pend = 0; m_ext = 0; m_brk = 0; m_err = 0; m_ovr = 0;
            m_irq_en = 0; m_irq = 0; m_pb = 0; m_skip = 0; m_ticks = 0;
        end else begin
            had_byte = m_pend;
            b        = m_pb;
            sz       = m_q.size();
            pend     = m_ext || m_brk || (m_skip > 0);
            m_irq    = m_irq_en && (sz > 0);
            m_pend   = 0;
            if (!m_ack && rx_done) begin
                m_pend = 1; m_pb = rx_data; m_ack = 1;
            end else if (m_ack && !rx_done) begin
                m_ack = 0;
            end
            if (cs && rd && addr) begin m_ovr = 0; m_err = 0; end
            popped = 0;
            if (cs && rd && !addr && sz > 0) begin void'(m_q.pop_front()); popped = 1; end
            do_push = 0;
            item    = 10'd0;
            if (had_byte) begin
                m_ticks = 0;
                if (m_skip > 0) m_skip--;
                else case (b)
                    8'hE0: m_ext = 1;
                    8'hF0: m_brk = 1;
                    8'hE1: begin do_push = 1; item = {2'b10, b}; m_ext = 0; m_brk = 0; m_skip = 7; end
                    8'h00, 8'hFF: begin m_err = 1; m_ext = 0; m_brk = 0; end
                    default: begin do_push = 1; item = {m_ext, m_brk, b}; m_ext = 0; m_brk = 0; end
                endcase
            end else if (pend && tim_tick) begin
                m_ticks++;
                if (m_ticks == TO_TICKS) begin m_ext = 0; m_brk = 0; m_skip = 0; m_ticks = 0; end
            end else if (!pend) begin
                m_ticks = 0;
            end
            if (cs && wr && addr) begin
                m_irq_en = din[1];
                if (din[0]) begin
                    m_q.delete(); m_ext = 0; m_brk = 0; m_skip = 0; m_ticks = 0; do_push = 0;
                end
            end
            if (do_push) begin
                if (sz < DEPTH || popped) m_q.push_back(item);
                else m_ovr = 1;
            end
        end
    end

    function automatic logic [7:0] exp_dout();
        logic [9:0] h;
        logic       ne;
        ne = (m_q.size() > 0);
        h  = ne ? m_q[0] : 10'd0;
        if (!addr) return h[7:0];
        return {ne, h[9], h[8], m_ovr, m_err, m_irq_en, 2'b00};
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (n_res) begin
            check("cyc_irq", {7'd0, irq}, {7'd0, m_irq});
            check("cyc_rx_ack", {7'd0, rx_ack}, {7'd0, m_ack});
            check("cyc_dout", dout, exp_dout());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input logic v, input string name);
        int k = 0;
        while (rx_ack !== v && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, {7'd0, rx_ack}, {7'd0, v});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        wait_ack(1'b1, "ack_rise");
        repeat (2) @(posedge clk);
        #1;
        check("ack_hold", {7'd0, rx_ack}, 8'h01);
        rx_done = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic read_reg(input logic a, input logic [7:0] exp, input string name);
        @(posedge clk); #1;
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        check(name, dout, exp);
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0; addr = 1'b0;
    endtask

    task automatic write_ctrl(input logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b1; addr = 1'b1; din = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; addr = 1'b0; din = 8'h00;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk); #1; tim_tick = 1'b1;
            @(posedge clk); #1; tim_tick = 1'b0;
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        #35 n_res = 1'b1;
        @(negedge clk);
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_ack", {7'd0, rx_ack}, 8'h00);
        check("rst_dout", dout, 8'h00);

        send_byte(8'h1C);
        read_reg(1'b1, 8'h80, "make_stat");
        read_reg(1'b0, 8'h1C, "make_data");
        read_reg(1'b1, 8'h00, "make_stat_empty");

        send_byte(8'hE0); send_byte(8'hF0);
        read_reg(1'b1, 8'h00, "prefix_no_evt");
        send_byte(8'h75);
        read_reg(1'b1, 8'hE0, "extbrk_stat");
        read_reg(1'b0, 8'h75, "extbrk_data");
        read_reg(1'b1, 8'h00, "extbrk_empty");

        for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
        send_byte(8'h1C);
        read_reg(1'b1, 8'hC0, "pause_stat");
        read_reg(1'b0, 8'hE1, "pause_data");
        read_reg(1'b1, 8'h80, "after_pause_stat");
        read_reg(1'b0, 8'h1C, "after_pause_data");
        read_reg(1'b1, 8'h00, "pause_empty");

        for (int i = 0; i < 9; i++) send_byte(8'(8'h15 + i));
        read_reg(1'b1, 8'h90, "ovr_stat");
        read_reg(1'b1, 8'h80, "ovr_cleared");
        for (int i = 0; i < 8; i++) read_reg(1'b0, 8'(8'h15 + i), "ovr_data");
        read_reg(1'b0, 8'h00, "empty_data");
        read_reg(1'b1, 8'h00, "empty_stat");

        send_byte(8'hF0);
        ticks(TO_TICKS - 1);
        send_byte(8'h1C);
        read_reg(1'b1, 8'hA0, "to_not_yet_stat");
        read_reg(1'b0, 8'h1C, "to_not_yet_data");
        send_byte(8'hF0);
        ticks(TO_TICKS + 1);
        send_byte(8'h1C);
        read_reg(1'b1, 8'h80, "to_cleared_stat");
        read_reg(1'b0, 8'h1C, "to_cleared_data");

        send_byte(8'h00);
        read_reg(1'b1, 8'h08, "err_stat");
        read_reg(1'b1, 8'h00, "err_cleared");

        send_byte(8'h2A);
        write_ctrl(8'h02);
        @(negedge clk);
        check("irq_lat0", {7'd0, irq}, 8'h00);
        @(negedge clk);
        check("irq_on", {7'd0, irq}, 8'h01);
        read_reg(1'b1, 8'h84, "irqen_stat");
        send_byte(8'hE0);
        write_ctrl(8'h03);
        @(negedge clk);
        @(negedge clk);
        check("irq_flushed", {7'd0, irq}, 8'h00);
        read_reg(1'b1, 8'h04, "flush_stat");
        send_byte(8'h1C);
        read_reg(1'b1, 8'h84, "flush_cleared_ext");

        @(posedge clk); #1;
        rx_data = 8'h33;
        rx_done = 1'b1;
        @(posedge clk); #1;
        check("ack_pre_reset", {7'd0, rx_ack}, 8'h01);
        #3 n_res = 1'b0;
        #1;
        check("ack_async_reset", {7'd0, rx_ack}, 8'h00);
        check("irq_async_reset", {7'd0, irq}, 8'h00);
        check("dout_async_reset", dout, 8'h00);
        rx_done = 1'b0;
        repeat (2) @(posedge clk);
        #5 n_res = 1'b1;
        read_reg(1'b1, 8'h00, "stat_after_reset");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Controller that sequences the PS/2 byte receiver and exposes keyboard events to the Z80 over a two-register I/O window. It runs the done/ack handshake with the receiver and folds E0/F0/E1 prefix bytes into single tagged events. Events are buffered in a small FIFO, and an interrupt is raised while events are pending.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..16
TO_TICKS, 1023, tim_tick pulses with no new byte before a dangling prefix is discarded (10-bit counter)

Ports:
clk  in  1  system clock, 50 MHz
n_res  in  1  asynchronous active-low reset
rx_done  in  1  receiver byte-available flag (ps2_done)
rx_data  in  8  receiver byte (ps2_out)
rx_ack  out  1  acknowledge to receiver (ps2_ack)
tim_tick  in  1  one-clk timeout tick, ~1 MHz
cs  in  1  I/O chip select
addr  in  1  0 = DATA, 1 = STATUS/CTRL
rd  in  1  one-clk read strobe, qualified by cs
wr  in  1  one-clk write strobe, qualified by cs
din  in  8  write data
dout  out  8  read data, combinational from addr/head
irq  out  1  interrupt, active high

Behaviour:
- Reset (asynchronous, n_res=0): rx_ack=0, FIFO empty, prefix flags clear, ovr=0, err=0, irq_en=0, skip counter 0, timeout counter 0, handshake FSM in WAIT. So irq=0 and dout=0x00 at addr 0.
- Handshake FSM, two states:
  - WAIT: when rx_done=1, capture rx_data into the decoder in that clk, set rx_ack=1, go to ACK.
  - ACK: hold rx_ack=1 until rx_done=0, then rx_ack=0 and return to WAIT. The receiver clears done only on its sample strobe, so ACK lasts more than one cycle.
  - Exactly one byte is decoded per rx_done assertion.
- Decoder, acting on each captured byte b:
  - b=0xE0: set ext, no push.
  - b=0xF0: set brk, no push.
  - b=0xE1: push {ext=1, brk=0, code=0xE1}, load skip=7; the next 7 bytes are discarded.
  - skip>0: decrement skip, no push.
  - b=0x00 or 0xFF: set sticky err, clear ext/brk, no push.
  - Any other byte: push {ext, brk, b}, then clear ext and brk.
- Prefix timeout:
  - The counter resets on every captured byte.
  - It increments on tim_tick while ext, brk or skip≠0.
  - On reaching TO_TICKS it clears ext, brk and skip, with no push.
- FIFO: entries are 10 bits {ext, brk, code}.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same clk.
  - Otherwise the push is dropped and sticky ovr is set.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
- DATA read (cs&rd&addr=0):
  - dout = head code; the entry is popped at the end of that clk.
  - When empty, dout=0x00 and no pointer change.
- STATUS read (addr=1):
  - dout = {nempty, head_ext, head_brk, ovr, err, irq_en, 2'b00}; head flags read 0 when empty.
  - A STATUS read clears ovr and err after the cycle. A set event in the same clk wins.
  - Software reads STATUS before DATA to get the head flags.
- CTRL write (cs&wr&addr=1):
  - din[0]=1 flushes the FIFO and clears the prefix/skip state. A push in the same clk is discarded.
  - din[1] loads irq_en.
  - Writes to addr 0 are ignored.
- irq = irq_en & nempty, registered (one clk latency after push/pop).
- Latency: rx_done rising → entry visible (nempty=1) at clk+2.

Decomposition:
- Shared include ps2_defs.vh: PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_PAUSE_SKIP=7, PS2_ERR0=8'h00, PS2_ERR1=8'hFF, register addresses, status bit positions.
- Sub-module ps2_evt_fifo: synchronous FIFO, parameterised width/depth, push/pop/flush, full/empty outputs, with the same-clk push+pop-when-full rule above.

Test Plan:
- Receiver delivers 0x1C → STATUS=0x80|irq_en bits, DATA=0x1C; a second STATUS read gives nempty=0; rx_ack asserted from capture until rx_done falls.
- Sequence E0,F0,75 → one event; STATUS bits7..5=111, DATA=0x75; no events for the prefix bytes.
- Sequence E1,14,77,E1,F0,14,F0,77 → exactly one event {1,0,0xE1}; a following 0x1C decodes as a plain make.
- 9 bytes pushed with FIFO_DEPTH=8 → 8 stored, ovr=1; the STATUS read clears ovr; a DATA read on an empty FIFO returns 0x00.
- F0 then 1024 tim_tick with no byte → brk cleared; a next 0x1C yields brk=0. The byte 0x00 sets err and nothing is pushed.
- CTRL write 0x02 with one event pending → irq=1 next clk; write 0x03 → FIFO flushed, irq=0. n_res low mid-ACK → rx_ack=0 immediately.
